// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue controller: op code values
//   ({funct7[5],funct3}), bit positions of the one-hot unit enable vector
//   and the issue FSM state encoding.
// Ports: none (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int NUM_UNITS = 10;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    // Enable vector layout {sltu,slt,sra,srl,sll,and,or,xor,sub,add}
    localparam int EN_ADD  = 0;
    localparam int EN_SUB  = 1;
    localparam int EN_XOR  = 2;
    localparam int EN_OR   = 3;
    localparam int EN_AND  = 4;
    localparam int EN_SLL  = 5;
    localparam int EN_SRL  = 6;
    localparam int EN_SRA  = 7;
    localparam int EN_SLT  = 8;
    localparam int EN_SLTU = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl_if
//   Request/response handshake bundle between the issue stage and the ALU
//   issue controller.
//   req_valid[1:0]   per-requester request valid
//   req_ready[1:0]   per-requester accept (one-hot or zero)
//   req_op0/1        4-bit op code per requester
//   req_rs1_0/1      operand A per requester
//   req_rs2_0/1      operand B per requester
//   rsp_valid/ready  response handshake
//   rsp_id           requester that issued the op
//   rsp_data         captured result
//   rsp_err          illegal op code flag
// Modports: master = issue side / bench, slave = controller.
// ----------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [3:0]      req_op0;
    logic [3:0]      req_op1;
    logic [XLEN-1:0] req_rs1_0;
    logic [XLEN-1:0] req_rs1_1;
    logic [XLEN-1:0] req_rs2_0;
    logic [XLEN-1:0] req_rs2_1;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_op0, req_op1,
               req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op0, req_op1,
               req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl_op_decode.sv
// ----------------------------------------------------------------------------
// alu_op_decode
//   Combinational decode of a 4-bit op code into the one-hot unit enable
//   vector plus an illegal-op flag. Illegal codes produce an all-zero enable.
//   op       in   4          op code {funct7[5],funct3}
//   en       out  NUM_UNITS  one-hot unit enable
//   illegal  out  1          op code not in the supported set
// ----------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0]           op,
    output logic [NUM_UNITS-1:0] en,
    output logic                 illegal
);

    always_comb begin
        en      = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  en[EN_ADD]  = 1'b1;
            OP_SUB:  en[EN_SUB]  = 1'b1;
            OP_SLL:  en[EN_SLL]  = 1'b1;
            OP_SLT:  en[EN_SLT]  = 1'b1;
            OP_SLTU: en[EN_SLTU] = 1'b1;
            OP_XOR:  en[EN_XOR]  = 1'b1;
            OP_SRL:  en[EN_SRL]  = 1'b1;
            OP_SRA:  en[EN_SRA]  = 1'b1;
            OP_OR:   en[EN_OR]   = 1'b1;
            OP_AND:  en[EN_AND]  = 1'b1;
            default: illegal     = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
//   Shares one single-issue integer ALU between two requesters: round-robin
//   arbitration, op decode to one-hot unit enables, fixed-latency wait via a
//   down-counter, result capture and a tagged valid/ready response.
//   clk          in   1          clock, rising edge
//   rst          in   1          asynchronous active-high reset
//   bus          slave           request/response handshake bundle
//   alu_en       out  NUM_UNITS  one-hot unit enable, only in EXEC
//   alu_rs1/rs2  out  XLEN       registered operands to all units
//   alu_result   in   XLEN       result of the enabled unit
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; req_ready one-hot to the winner
//   EXEC    | unit enabled, counting down ALU_LAT cycles to sampling
//   RESP    | response held on rsp_* until rsp_valid && rsp_ready
// ----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_issue_ctrl_if.slave      bus,
    output logic [NUM_UNITS-1:0] alu_en,
    output logic [XLEN-1:0]      alu_rs1,
    output logic [XLEN-1:0]      alu_rs2,
    input  logic [XLEN-1:0]      alu_result
);

    state_t                 state;
    logic                   rr_ptr;
    logic [3:0]             cnt;

    logic                   any_valid;
    logic                   winner;
    logic [3:0]             sel_op;
    logic [NUM_UNITS-1:0]   dec_en;
    logic                   dec_illegal;

    // With both requesters valid rr_ptr picks; otherwise the lone valid one wins.
    assign any_valid = |bus.req_valid;
    assign winner    = (bus.req_valid == 2'b11) ? rr_ptr : bus.req_valid[1];
    assign sel_op    = winner ? bus.req_op1 : bus.req_op0;

    assign bus.req_ready = (state == ST_IDLE && any_valid)
                         ? (winner ? 2'b10 : 2'b01) : 2'b00;

    alu_op_decode u_decode (
        .op      (sel_op),
        .en      (dec_en),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= 1'b0;
            cnt           <= '0;
            alu_en        <= '0;
            alu_rs1       <= '0;
            alu_rs2       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        alu_rs1    <= winner ? bus.req_rs1_1 : bus.req_rs1_0;
                        alu_rs2    <= winner ? bus.req_rs2_1 : bus.req_rs2_0;
                        bus.rsp_id <= winner;
                        rr_ptr     <= ~winner;
                        cnt        <= 4'(ALU_LAT - 1);
                        if (dec_illegal) begin
                            bus.rsp_data  <= '0;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= ST_RESP;
                        end else begin
                            alu_en      <= dec_en;
                            bus.rsp_err <= 1'b0;
                            state       <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == 4'd0) begin
                        bus.rsp_data  <= alu_result;
                        bus.rsp_valid <= 1'b1;
                        alu_en        <= '0;
                        state         <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    alu_en        <= '0;
                    bus.rsp_valid <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
